game_state_fsm: RTL and testbench
=================================

Name: game_state_fsm

Overview:
- Game-progress controller upstream of the Obstacles, Scrolls and Screens stages.
- Turns the start button and the player-status code into the `world` and `level` selectors those stages consume, plus the game status and lives count.
- Fills the slot the top level currently ties to raw switches (World, Level, playerStatus).
- Holds each transition state (level-up, world-up, life-lost) for a fixed display interval so Screens can show a banner.

Parameters:
- NUM_WORLDS, 4: worlds in the game, range 1..8.
- LEVELS_PER_WORLD, 6: levels per world, range 1..8.
- START_LIVES, 3: lives loaded at game start, range 1..15.
- HOLD_CYCLES, 100000000: clk cycles each transition state is held; minimum 1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start_btn  in  1  raw start button, asynchronous to clk, active-high.
- player_status  in  2  0 = playing, 1 = level passed, 2 = player died, 3 = reserved (treated as 0).
- game_status  out  3  0 START, 1 PLAYING, 2 LEVEL_INC, 3 WORLD_INC, 4 LIFE_LOST, 5 LOSE, 6 WIN.
- world  out  3  current world index, 0-based.
- level  out  3  current level index within the world, 0-based.
- lives  out  4  remaining lives.

Behaviour:
- Reset (rst = 0, async) gives: state START, game_status 0, world 0, level 0, lives START_LIVES, hold timer 0, armed 0, synchroniser flops 0.
  - Reset asserted mid-hold aborts the hold with no residual update.
- start_btn passes through a 2-flop synchroniser, then a rising-edge detector, producing start_pulse.
  - start_pulse is one cycle wide and arrives 3 cycles after the button edge.
  - A held button gives exactly one pulse.
- game_status is a registered copy of the state encoding. world, level and lives are registered and change only on state-transition edges.
- START
  - On start_pulse: world ← 0, level ← 0, lives ← START_LIVES, armed ← 0, go to PLAYING.
- PLAYING
  - armed is set on any cycle where player_status ∈ {0, 3}.
  - While armed = 0, player_status 1 and 2 are ignored. This prevents double-counting a status code that is still asserted after a transition.
  - armed = 1 and status 1 (level passed):
    - level < LEVELS_PER_WORLD−1: level ← level+1, go to LEVEL_INC.
    - else, world < NUM_WORLDS−1: world ← world+1, level ← 0, go to WORLD_INC.
    - else: go to WIN; world and level are unchanged.
  - armed = 1 and status 2 (died):
    - lives > 1: lives ← lives−1, go to LIFE_LOST; level is unchanged.
    - lives == 1: lives ← 0, go to LOSE.
  - start_pulse is ignored.
- LEVEL_INC, WORLD_INC, LIFE_LOST
  - The hold timer clears on entry and increments each cycle.
  - When the timer reaches HOLD_CYCLES−1: go to PLAYING, armed ← 0.
  - Dwell is exactly HOLD_CYCLES cycles; game_status reads the transition code for all of them.
  - player_status and start_pulse are ignored.
- LOSE, WIN
  - Terminal states. On start_pulse: go to START.
  - Outputs keep their last values until START exits.
- Arithmetic:
  - Increments are unsigned and guarded by the compares above, so they never wrap.
  - The hold timer is 32 bits.
  - Out-of-range parameters are a static error (elaboration assertion).

Decomposition:
- Shared package `game_pkg` holds:
  - the game_status encodings (GS_START = 0 … GS_WIN = 6);
  - the player_status codes (PS_PLAYING, PS_PASS, PS_DIED);
  - state type width constants.
- Sub-module `btn_sync_edge` (2-flop synchroniser plus rising-edge pulse, clk/rst) is reused later for other buttons.
- The FSM, counters and hold timer stay in `game_state_fsm`.

Test Plan:
All cases use NUM_WORLDS=2, LEVELS_PER_WORLD=3, START_LIVES=3, HOLD_CYCLES=4.
1. Reset, then start_btn high for 10 cycles → exactly one START→PLAYING transition, 4 cycles after the button edge (3-cycle pulse latency plus the state register). Outputs: game_status=1, world=0, level=0, lives=3. Holding the button longer gives no further effect.
2. In PLAYING, hold player_status=1 for 20 cycles → one LEVEL_INC lasting exactly 4 cycles, level=1, then PLAYING. No second increment until player_status has returned to 0 for at least one cycle.
3. Pass 5 levels, de-asserting status between each → level 0→1→2, then WORLD_INC with world=1, level=0, then 1→2. The sixth pass → WIN (game_status=6) with world=1, level=2.
4. Send status=2 three times, each separated by status 0 → LIFE_LOST with lives 2, then LIFE_LOST with lives 1, then LOSE with lives=0. Level is unchanged throughout. start_pulse in LOSE → START.
5. Drive rst low for 1 cycle on the 2nd cycle of a WORLD_INC hold → immediate START with world=0, level=0, lives=3, game_status=0. No PLAYING re-entry without start_pulse.
6. player_status=3 held in PLAYING → no transition. start_pulse during LEVEL_INC or PLAYING → ignored; the state sequence is unchanged.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game-progress controller and its consumers.
package game_pkg;

    localparam int unsigned GS_W   = 3;
    localparam int unsigned PS_W   = 2;
    localparam int unsigned HOLD_W = 32;

    // Game status codes as seen by Obstacles, Scrolls and Screens
    typedef enum logic [GS_W-1:0] {
        GS_START     = 3'd0,
        GS_PLAYING   = 3'd1,
        GS_LEVEL_INC = 3'd2,
        GS_WORLD_INC = 3'd3,
        GS_LIFE_LOST = 3'd4,
        GS_LOSE      = 3'd5,
        GS_WIN       = 3'd6
    } gameState_e;

    // Player status codes; code 3 is reserved and behaves like PS_PLAYING
    localparam logic [PS_W-1:0] PS_PLAYING  = 2'd0;
    localparam logic [PS_W-1:0] PS_PASS     = 2'd1;
    localparam logic [PS_W-1:0] PS_DIED     = 2'd2;
    localparam logic [PS_W-1:0] PS_RESERVED = 2'd3;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btnAsync,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic syncPrev;

    // Synchronise, remember the previous synchronised level, register the edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            syncPrev <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            sync1    <= btnAsync;
            sync2    <= sync1;
            syncPrev <= sync2;
            pulse    <= sync2 & ~syncPrev;
        end
    end

endmodule

// File: rtl/game_state_fsm.sv
// Game-progress controller: start button and player status in, world/level/lives/status out.
module game_state_fsm
    import game_pkg::*;
#(
    parameter int unsigned NUM_WORLDS       = 4,
    parameter int unsigned LEVELS_PER_WORLD = 6,
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned HOLD_CYCLES      = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [1:0] player_status,
    output logic [2:0] game_status,
    output logic [2:0] world,
    output logic [2:0] level,
    output logic [3:0] lives
);

    if (NUM_WORLDS < 1 || NUM_WORLDS > 8) begin : gBadWorlds
        $error("NUM_WORLDS must be in 1..8");
    end
    if (LEVELS_PER_WORLD < 1 || LEVELS_PER_WORLD > 8) begin : gBadLevels
        $error("LEVELS_PER_WORLD must be in 1..8");
    end
    if (START_LIVES < 1 || START_LIVES > 15) begin : gBadLives
        $error("START_LIVES must be in 1..15");
    end
    if (HOLD_CYCLES < 1) begin : gBadHold
        $error("HOLD_CYCLES must be at least 1");
    end

    localparam logic [2:0]        LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
    localparam logic [2:0]        LAST_WORLD = 3'(NUM_WORLDS - 1);
    localparam logic [3:0]        INIT_LIVES = 4'(START_LIVES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);

    logic startPulse;

    gameState_e        stateQ,  stateD;
    logic [2:0]        worldQ,  worldD;
    logic [2:0]        levelQ,  levelD;
    logic [3:0]        livesQ,  livesD;
    logic [HOLD_W-1:0] holdQ,   holdD;
    logic              armedQ,  armedD;

    btn_sync_edge uStartSync (
        .clk      (clk),
        .rst      (rst),
        .btnAsync (start_btn),
        .pulse    (startPulse)
    );

    // State, counters, hold timer and re-arm flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= GS_START;
            worldQ <= 3'd0;
            levelQ <= 3'd0;
            livesQ <= INIT_LIVES;
            holdQ  <= '0;
            armedQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            worldQ <= worldD;
            levelQ <= levelD;
            livesQ <= livesD;
            holdQ  <= holdD;
            armedQ <= armedD;
        end
    end

    // Next-state and counter updates
    always_comb begin
        stateD = stateQ;
        worldD = worldQ;
        levelD = levelQ;
        livesD = livesQ;
        holdD  = holdQ;
        armedD = armedQ;

        case (stateQ)
            GS_START: begin
                if (startPulse) begin
                    worldD = 3'd0;
                    levelD = 3'd0;
                    livesD = INIT_LIVES;
                    armedD = 1'b0;
                    stateD = GS_PLAYING;
                end
            end
            GS_PLAYING: begin
                // A status code left over from the last transition is ignored until re-armed
                if (armedQ && player_status == PS_PASS) begin
                    holdD = '0;
                    if (levelQ < LAST_LEVEL) begin
                        levelD = levelQ + 3'd1;
                        stateD = GS_LEVEL_INC;
                    end else if (worldQ < LAST_WORLD) begin
                        worldD = worldQ + 3'd1;
                        levelD = 3'd0;
                        stateD = GS_WORLD_INC;
                    end else begin
                        stateD = GS_WIN;
                    end
                end else if (armedQ && player_status == PS_DIED) begin
                    holdD = '0;
                    if (livesQ > 4'd1) begin
                        livesD = livesQ - 4'd1;
                        stateD = GS_LIFE_LOST;
                    end else begin
                        livesD = 4'd0;
                        stateD = GS_LOSE;
                    end
                end else if (player_status == PS_PLAYING || player_status == PS_RESERVED) begin
                    armedD = 1'b1;
                end
            end
            GS_LEVEL_INC, GS_WORLD_INC, GS_LIFE_LOST: begin
                if (holdQ == HOLD_LAST) begin
                    stateD = GS_PLAYING;
                    armedD = 1'b0;
                end else begin
                    holdD = holdQ + 32'd1;
                end
            end
            GS_LOSE, GS_WIN: begin
                if (startPulse) begin
                    stateD = GS_START;
                end
            end
            default: begin
                stateD = GS_START;
            end
        endcase
    end

    assign game_status = stateQ;
    assign world       = worldQ;
    assign level       = levelQ;
    assign lives       = livesQ;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed plus randomized bench for game_state_fsm against a progress-index reference model.
module tb_game_state_fsm;

    localparam int NW    = 2;
    localparam int NL    = 3;
    localparam int LIVES = 3;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic [1:0] player_status;
    logic [2:0] game_status;
    logic [2:0] world;
    logic [2:0] level;
    logic [3:0] lives;

    int checks   = 0;
    int failures = 0;

    // Reference model: game progress as one index over all levels of all worlds
    int   mGs;
    int   mProg;
    int   mLives;
    bit   mArmed;
    int   mHoldLeft;
    bit   bHist [4];

    logic       rb;
    logic [1:0] rp;
    int         guard;

    always #5 clk = ~clk;

    game_state_fsm #(
        .NUM_WORLDS       (NW),
        .LEVELS_PER_WORLD (NL),
        .START_LIVES      (LIVES),
        .HOLD_CYCLES      (HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .player_status (player_status),
        .game_status   (game_status),
        .world         (world),
        .level         (level),
        .lives         (lives)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mGs = 0; mProg = 0; mLives = LIVES; mArmed = 0; mHoldLeft = 0;
        for (int i = 0; i < 4; i++) bHist[i] = 1'b0;
    endtask

    task automatic modelStep(input logic btn, input logic [1:0] ps);
        bit pulse;
        pulse = bHist[2] & ~bHist[3];
        bHist[3] = bHist[2]; bHist[2] = bHist[1]; bHist[1] = bHist[0]; bHist[0] = btn;
        case (mGs)
            0: if (pulse) begin mGs = 1; mProg = 0; mLives = LIVES; mArmed = 0; end
            1: begin
                if (mArmed && ps == 2'd1) begin
                    if (mProg == NW * NL - 1) mGs = 6;
                    else begin
                        mProg++;
                        mGs = (mProg % NL == 0) ? 3 : 2;
                        mHoldLeft = HOLD;
                    end
                end else if (mArmed && ps == 2'd2) begin
                    mLives--;
                    mGs = (mLives == 0) ? 5 : 4;
                    mHoldLeft = HOLD;
                end else if (ps == 2'd0 || ps == 2'd3) begin
                    mArmed = 1;
                end
            end
            2, 3, 4: begin
                mHoldLeft--;
                if (mHoldLeft == 0) begin mGs = 1; mArmed = 0; end
            end
            default: if (pulse) mGs = 0;
        endcase
    endtask

    task automatic checkModel();
        check("status", 32'(game_status), 32'(mGs));
        check("world",  32'(world),       32'(mProg / NL));
        check("level",  32'(level),       32'(mProg % NL));
        check("lives",  32'(lives),       32'(mLives));
    endtask

    task automatic cycle(input logic btn, input logic [1:0] ps);
        start_btn = btn;
        player_status = ps;
        @(posedge clk);
        modelStep(btn, ps);
        #1;
        checkModel();
    endtask

    task automatic pressStart();
        repeat (5) cycle(1'b1, 2'd0);
        repeat (3) cycle(1'b0, 2'd0);
    endtask

    task automatic passLevel();
        cycle(1'b0, 2'd1);
        repeat (HOLD + 2) cycle(1'b0, 2'd0);
    endtask

    task automatic doReset();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkModel();
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkModel();
    endtask

    initial begin
        rst = 1'b0;
        start_btn = 1'b0;
        player_status = 2'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", 32'(game_status), 32'd0);
        check("rst_world",  32'(world),       32'd0);
        check("rst_level",  32'(level),       32'd0);
        check("rst_lives",  32'(lives),       32'd3);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 2'd0);

        // 1: held start button, entry 4 cycles after the edge, one pulse only
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'd0);
            check("start_latency", 32'(game_status), (i >= 3) ? 32'd1 : 32'd0);
        end
        repeat (3) cycle(1'b0, 2'd0);

        // 2: held pass status gives one level-up of exactly HOLD cycles
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 2'd1);
            check("hold_dwell", 32'(game_status), (i < HOLD) ? 32'd2 : 32'd1);
        end
        check("one_inc_level", 32'(level), 32'd1);
        repeat (2) cycle(1'b0, 2'd0);

        // 3: pass through to the end of the last world
        guard = 0;
        while (mGs != 6 && guard < 10) begin
            passLevel();
            guard++;
        end
        check("win_status", 32'(game_status), 32'd6);
        check("win_world",  32'(world),       32'd1);
        check("win_level",  32'(level),       32'd2);
        pressStart();
        check("win_to_start", 32'(game_status), 32'd0);
        pressStart();

        // 4: three deaths, level kept, then restart from LOSE
        passLevel();
        for (int d = 0; d < 3; d++) begin
            cycle(1'b0, 2'd2);
            repeat (HOLD + 2) cycle(1'b0, 2'd0);
        end
        check("lose_status", 32'(game_status), 32'd5);
        check("lose_lives",  32'(lives),       32'd0);
        check("lose_level",  32'(level),       32'd1);
        pressStart();
        check("lose_to_start", 32'(game_status), 32'd0);

        // 5: reset on the second cycle of a world-up hold
        pressStart();
        passLevel();
        passLevel();
        cycle(1'b0, 2'd1);
        cycle(1'b0, 2'd0);
        check("pre_rst_worldinc", 32'(game_status), 32'd3);
        doReset();
        repeat (6) cycle(1'b0, 2'd0);
        check("post_rst_idle", 32'(game_status), 32'd0);

        // 6: reserved status and stray start pulses have no effect
        pressStart();
        repeat (10) cycle(1'b0, 2'd3);
        check("reserved_no_move", 32'(game_status), 32'd1);
        repeat (6) cycle(1'b1, 2'd0);
        cycle(1'b0, 2'd0);
        cycle(1'b1, 2'd1);
        repeat (5) cycle(1'b1, 2'd0);
        repeat (6) cycle(1'b0, 2'd0);
        check("pulse_ignored", 32'(game_status), 32'd1);

        // Randomized run against the reference model
        rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) doReset();
            if ($urandom_range(0, 11) == 0) rb = ~rb;
            rp = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            cycle(rb, rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
